// File: rtl/bus_arbiter2_pkg.sv
// rtl/bus_arbiter2_pkg.sv - shared state encodings and defaults for the two-requester bus arbiter
package bus_arbiter2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_t;

    localparam int DEF_N       = 16;
    localparam int DEF_MAXHOLD = 8;

    // Grant vector implied by a state; IDLE and any unused code grant nobody.
    function automatic logic [1:0] grant_of(input arb_state_t st);
        case (st)
            ST_OWN0: grant_of = 2'b01;
            ST_OWN1: grant_of = 2'b10;
            default: grant_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter2_mux2.sv
// rtl/bus_arbiter2_mux2.sv - parameterized 2:1 datapath mux
module bus_arbiter2_mux2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/bus_arbiter2.sv
// rtl/bus_arbiter2.sv - two-requester bus arbiter with hold limit, fairness and registered shared datapath
module bus_arbiter2
    import bus_arbiter2_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int MAXHOLD = DEF_MAXHOLD
) (
    input  logic         Clk,
    input  logic         Resetn,
    input  logic [1:0]   R,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [1:0]   G,
    output logic         S,
    output logic [N-1:0] F,
    output logic         V
);

    // Counter value during the last permitted owned cycle.
    localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

    arb_state_t   state;
    arb_state_t   next_state;
    logic [7:0]   hold_cnt;
    logic         last_owner;
    logic         expire;
    logic [N-1:0] mux_y;

    bus_arbiter2_mux2 #(
        .W (N)
    ) u_mux (
        .a   (X),
        .b   (Y),
        .sel (S),
        .y   (mux_y)
    );

    assign expire = (hold_cnt == HOLD_LAST);

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                case (R)
                    2'b01:   next_state = ST_OWN0;
                    2'b10:   next_state = ST_OWN1;
                    2'b11:   next_state = last_owner ? ST_OWN0 : ST_OWN1;
                    default: next_state = ST_IDLE;
                endcase
            end
            ST_OWN0: begin
                if (!R[0] || expire)
                    next_state = R[1] ? ST_OWN1 : ST_IDLE;
            end
            ST_OWN1: begin
                if (!R[1] || expire)
                    next_state = R[0] ? ST_OWN0 : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state      <= ST_IDLE;
            hold_cnt   <= 8'd0;
            last_owner <= 1'b1;
            G          <= 2'b00;
            S          <= 1'b0;
            F          <= '0;
            V          <= 1'b0;
        end else begin
            state <= next_state;
            G     <= grant_of(next_state);

            if (next_state != state)
                hold_cnt <= 8'd0;
            else if (state != ST_IDLE)
                hold_cnt <= hold_cnt + 8'd1;

            // Select and fairness flag follow the owner; both hold through IDLE.
            if (next_state == ST_OWN0) begin
                S          <= 1'b0;
                last_owner <= 1'b0;
            end else if (next_state == ST_OWN1) begin
                S          <= 1'b1;
                last_owner <= 1'b1;
            end

            if (state != ST_IDLE)
                F <= mux_y;
            V <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb/tb_bus_arbiter2.sv - directed self-checking bench for bus_arbiter2
module tb_bus_arbiter2;

    localparam int N = 16;

    logic         Clk;
    logic         Resetn;
    logic [1:0]   R;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic [1:0]   G;
    logic         S;
    logic [N-1:0] F;
    logic         V;

    int checks = 0;
    int errors = 0;

    bus_arbiter2 #(.N(N), .MAXHOLD(8)) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .R      (R),
        .X      (X),
        .Y      (Y),
        .G      (G),
        .S      (S),
        .F      (F),
        .V      (V)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        R      = 2'b00;
        tick();
        tick();
        Resetn = 1'b1;
    endtask

    function automatic logic [1:0] contention_g(input int t);
        contention_g = (((t - 1) / 8) % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic test_reset();
        Resetn = 1'b0;
        R      = 2'b11;
        X      = 16'hA5A5;
        Y      = 16'h5A5A;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (G !== 2'b00 || S !== 1'b0 || F !== 16'h0000 || V !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: G=%b S=%b F=%h V=%b, required G=00 S=0 F=0000 V=0", i, G, S, F, V);
            end
        end
        Resetn = 1'b1;
        tick();
        checks++;
        if (G !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: G=%b, required 01", G);
        end
    endtask

    task automatic test_single();
        do_reset();
        Y = 16'hBEEF;
        R = 2'b10;
        tick();
        checks++;
        if (G !== 2'b10 || S !== 1'b1 || V !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: G=%b S=%b V=%b, required G=10 S=1 V=0", G, S, V);
        end
        tick();
        checks++;
        if (V !== 1'b1 || F !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_data: V=%b F=%h, required V=1 F=beef", V, F);
        end
        for (int i = 3; i <= 8; i++) begin
            tick();
            checks++;
            if (G !== 2'b10) begin
                errors++;
                $display("FAIL single_hold cycle %0d: G=%b, required 10", i, G);
            end
        end
        tick();
        checks++;
        if (G !== 2'b00 || V !== 1'b1 || S !== 1'b1) begin
            errors++;
            $display("FAIL single_release: G=%b V=%b S=%b, required G=00 V=1 S=1", G, V, S);
        end
        tick();
        checks++;
        if (G !== 2'b10 || V !== 1'b0 || F !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_regrant: G=%b V=%b F=%h, required G=10 V=0 F=beef", G, V, F);
        end
        R = 2'b00;
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_f;
        do_reset();
        X = 16'h1111;
        Y = 16'h2222;
        R = 2'b11;
        for (int t = 1; t <= 24; t++) begin
            tick();
            checks++;
            if (G !== contention_g(t)) begin
                errors++;
                $display("FAIL contention_grant t=%0d: G=%b, required %b", t, G, contention_g(t));
            end
            if (t >= 2) begin
                exp_f = (contention_g(t - 1) == 2'b01) ? 16'h1111 : 16'h2222;
                checks++;
                if (F !== exp_f || V !== 1'b1) begin
                    errors++;
                    $display("FAIL contention_data t=%0d: F=%h V=%b, required F=%h V=1", t, F, V, exp_f);
                end
            end
        end
        R = 2'b00;
    endtask

    task automatic test_early_release();
        do_reset();
        R = 2'b11;
        for (int t = 1; t <= 4; t++) tick();
        checks++;
        if (G !== 2'b01) begin
            errors++;
            $display("FAIL early_owner0: G=%b, required 01", G);
        end
        R = 2'b10;
        tick();
        checks++;
        if (G !== 2'b10 || S !== 1'b1) begin
            errors++;
            $display("FAIL early_handover: G=%b S=%b, required G=10 S=1", G, S);
        end
        R = 2'b11;
        for (int t = 6; t <= 12; t++) begin
            tick();
            checks++;
            if (G !== 2'b10) begin
                errors++;
                $display("FAIL early_fresh_hold t=%0d: G=%b, required 10", t, G);
            end
        end
        tick();
        checks++;
        if (G !== 2'b01) begin
            errors++;
            $display("FAIL early_expire: G=%b, required 01", G);
        end
        R = 2'b00;
    endtask

    task automatic test_async_reset();
        do_reset();
        Y = 16'h3C3C;
        R = 2'b10;
        tick();
        tick();
        checks++;
        if (G !== 2'b10 || V !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: G=%b V=%b, required G=10 V=1", G, V);
        end
        #2;
        Resetn = 1'b0;
        #1;
        checks++;
        if (G !== 2'b00 || V !== 1'b0 || S !== 1'b0 || F !== 16'h0000) begin
            errors++;
            $display("FAIL async_abort: G=%b V=%b S=%b F=%h, required G=00 V=0 S=0 F=0000", G, V, S, F);
        end
        R = 2'b11;
        tick();
        Resetn = 1'b1;
        tick();
        checks++;
        if (G !== 2'b01) begin
            errors++;
            $display("FAIL async_restart: G=%b, required 01", G);
        end
        R = 2'b00;
    endtask

    task automatic test_fairness();
        do_reset();
        R = 2'b10;
        tick();
        R = 2'b00;
        tick();
        R = 2'b11;
        tick();
        checks++;
        if (G !== 2'b01) begin
            errors++;
            $display("FAIL fair_after_1: G=%b, required 01", G);
        end
        R = 2'b00;
        tick();
        checks++;
        if (G !== 2'b00 || S !== 1'b0) begin
            errors++;
            $display("FAIL fair_idle: G=%b S=%b, required G=00 S=0", G, S);
        end
        R = 2'b11;
        tick();
        checks++;
        if (G !== 2'b10) begin
            errors++;
            $display("FAIL fair_after_0: G=%b, required 10", G);
        end
        R = 2'b00;
    endtask

    initial begin
        Resetn = 1'b0;
        R      = 2'b00;
        X      = '0;
        Y      = '0;
        test_reset();
        test_single();
        test_contention();
        test_early_release();
        test_async_reset();
        test_fairness();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 Parameter N, default 16, width of each requester data word and of the shared output.
REQ-002 Parameter MAXHOLD, default 8, maximum consecutive cycles one requester may hold the grant (legal range 1..255).
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Resetn  input  1  reset, asynchronous and active-low.
REQ-005 R  input  2  request lines; R[0] requester 0, R[1] requester 1.
REQ-006 X  input  N  data from requester 0.
REQ-007 Y  input  N  data from requester 1.
REQ-008 G  output  2  registered one-hot-or-zero grant; G[i]=1 means requester i owns the path.
REQ-009 S  output  1  registered select for the shared 2:1 datapath mux; 0 selects X, 1 selects Y.
REQ-010 F  output  N  registered shared data output.
REQ-011 V  output  1  registered valid; 1 when F holds data of a granted requester.

Function
REQ-012 FSM states IDLE, OWN0, OWN1; encoding private to the module.
REQ-013 IDLE: R=00 stays IDLE; R=01 goes OWN0; R=10 goes OWN1; R=11 goes to the requester not served last (LastOwner flag), requester 0 if none served since reset.
REQ-014 OWN0: stays while R[0]=1 and hold count < MAXHOLD; on R[0]=0 or count reaching MAXHOLD, goes OWN1 if R[1]=1, else IDLE.
REQ-015 OWN1: symmetric to OWN0 with roles swapped.
REQ-016 Hold counter clears on every state change and increments each cycle in OWN0/OWN1; expiry at count = MAXHOLD forces release even when the owner keeps requesting.
REQ-017 After forced release with the other side idle, the former owner returns through IDLE, so it is granted again no sooner than 2 cycles later.
REQ-018 Grant latency: request sampled at edge k with the path free yields G/S valid after edge k+1 (1 cycle).
REQ-019 G = 01 in OWN0, 10 in OWN1, 00 in IDLE; G=11 is never produced.
REQ-020 S = 0 in OWN0, 1 in OWN1; S holds its last value in IDLE.
REQ-021 F is registered from the mux output: F(k+1) = X(k) if S(k)=0 else Y(k), and only updated while the state is OWN0/OWN1; F holds in IDLE.
REQ-022 V(k+1) = 1 if and only if the state at cycle k is OWN0 or OWN1; F/V lag G by exactly 1 cycle.
REQ-023 Owner switch OWN0->OWN1 is direct (no idle cycle); LastOwner updates on every entry to OWN0/OWN1.
REQ-024 Owner dropping its request in the same cycle the other raises one: handover occurs on that edge, no cycle lost.

Reset
REQ-025 Resetn=0 immediately forces state IDLE, counter 0, LastOwner=1 (so requester 0 wins first tie), G=00, S=0, F=0, V=0, independent of Clk.
REQ-026 Reset asserted mid-ownership aborts the grant; after release, arbitration restarts from IDLE on the first rising edge with Resetn=1.

Structure
REQ-027 Shared package holds state encodings (IDLE, OWN0, OWN1) and the default N and MAXHOLD constants.
REQ-028 Datapath selection instantiates the team's existing parameterized 2:1 mux (N-bit, select S, inputs X/Y) as the only sub-module; output register and FSM live in bus_arbiter2.

Verification
REQ-029 Reset: Resetn=0 for 3 cycles with R=11 -> G=00, S=0, F=0, V=0 throughout; first edge after release grants requester 0 (G=01).
REQ-030 Single requester: R=10, Y=16'hBEEF, MAXHOLD=8 -> G=10, S=1 one cycle later, V=1 and F=16'hBEEF the cycle after; G drops after 8 owned cycles, returns 2 cycles later.
REQ-031 Contention: R=11 held, X=16'h1111, Y=16'h2222 -> G alternates 01/10 every 8 cycles with no idle gap; F alternates 1111/2222 one cycle behind G.
REQ-032 Early release: OWN0 at count 3, R goes 11->10 -> next cycle G=10, counter restarts at 0.
REQ-033 Async reset mid-grant: assert Resetn=0 between edges while G=10 -> G=00, V=0 immediately, without a clock edge.
REQ-034 Fairness: after requester 1 last served, IDLE with R=11 -> G=01; after requester 0 last served -> G=10.
